// File: rtl/y86_pipe_ctrl.sv
// Y86-64 five-stage pipeline hazard/control unit: stall and bubble generation,
// sticky processor status and saturating performance counters.
module y86_pipe_ctrl #(
    parameter int unsigned CNT_W  = 32,
    parameter bit          FWD_EN = 1'b1,
    parameter logic [3:0]  RNONE  = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_dstE,
    input  logic [3:0]       e_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       m_icode,
    input  logic [3:0]       m_dstE,
    input  logic [3:0]       m_dstM,
    input  logic [2:0]       m_status,
    input  logic [3:0]       w_icode,
    input  logic [3:0]       w_dstE,
    input  logic [3:0]       w_dstM,
    input  logic [2:0]       w_status,
    output logic             f_stall,
    output logic             d_stall,
    output logic             d_bubble,
    output logic             e_bubble,
    output logic             m_bubble,
    output logic             w_stall,
    output logic             set_cc,
    output logic [2:0]       proc_status,
    output logic             halted,
    output logic [CNT_W-1:0] cnt_cycles,
    output logic [CNT_W-1:0] cnt_retired,
    output logic [CNT_W-1:0] cnt_stalls,
    output logic [CNT_W-1:0] cnt_bubbles
);

    // state   | meaning
    // ST_RUN  | pipeline running, counters and status latch live
    // ST_HALT | exception retired from W; status frozen until rst

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [2:0] S_AOK   = 3'd1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;

    logic load_use;
    logic raw;
    logic data_hz;
    logic mispredict;
    logic ret_hz;
    logic exc_m;
    logic exc_w;
    logic retire;

    function automatic logic hits_any(input logic [3:0] src,
                                      input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c, input logic [3:0] d,
                                      input logic [3:0] e, input logic [3:0] f);
        return (src != RNONE) &&
               (src == a || src == b || src == c || src == d || src == e || src == f);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign load_use = (e_icode == I_MRMOV || e_icode == I_POP) && (e_dstM != RNONE) &&
                      (e_dstM == d_srcA || e_dstM == d_srcB);

    // Without forwarding every in-flight writer of a D source is a hazard, W included.
    assign raw = hits_any(d_srcA, e_dstE, e_dstM, m_dstE, m_dstM, w_dstE, w_dstM) ||
                 hits_any(d_srcB, e_dstE, e_dstM, m_dstE, m_dstM, w_dstE, w_dstM);

    assign data_hz    = FWD_EN ? load_use : raw;
    assign mispredict = (e_icode == I_JXX) && !e_cnd;
    assign ret_hz     = (d_icode == I_RET) || (e_icode == I_RET) || (m_icode == I_RET);
    assign exc_m      = (m_status != S_AOK);
    assign exc_w      = (w_status != S_AOK);
    assign halted     = (state == ST_HALT);
    assign retire     = (w_status == S_AOK) && (w_icode != I_NOP);

    assign f_stall  = !rst && ((data_hz && !mispredict) || ret_hz);
    assign d_stall  = !rst && data_hz && !mispredict;
    assign d_bubble = !rst && (mispredict || (ret_hz && !data_hz));
    assign e_bubble = !rst && (mispredict || data_hz);
    assign m_bubble = !rst && (exc_m || exc_w || halted);
    assign w_stall  = !rst && (exc_w || halted);
    assign set_cc   = !rst && (e_icode == I_OPQ) && !exc_m && !exc_w && !halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            proc_status <= S_AOK;
            cnt_cycles  <= '0;
            cnt_retired <= '0;
            cnt_stalls  <= '0;
            cnt_bubbles <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    cnt_cycles <= sat_inc(cnt_cycles);
                    if (retire)
                        cnt_retired <= sat_inc(cnt_retired);
                    if (f_stall)
                        cnt_stalls <= sat_inc(cnt_stalls);
                    if (d_bubble || e_bubble)
                        cnt_bubbles <= sat_inc(cnt_bubbles);
                    if (exc_w) begin
                        state       <= ST_HALT;
                        proc_status <= w_status;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// Self-checking bench for y86_pipe_ctrl: forwarding, non-forwarding and
// narrow-counter instances share stimulus; table vectors plus hand sequences.
module tb_y86_pipe_ctrl;

    localparam logic [3:0] RN    = 4'hF;
    localparam logic [3:0] NOP   = 4'h1;
    localparam logic [3:0] IRMOV = 4'h3;
    localparam logic [3:0] MRMOV = 4'h5;
    localparam logic [3:0] OPQ   = 4'h6;
    localparam logic [3:0] JXX   = 4'h7;
    localparam logic [3:0] RET   = 4'h9;
    localparam logic [3:0] POP   = 4'hB;
    localparam logic [2:0] AOK   = 3'd1;
    localparam logic [2:0] HLT   = 3'd2;
    localparam logic [2:0] ADR   = 3'd3;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] d_icode, d_srcA, d_srcB, e_icode, e_dstE, e_dstM;
    logic       e_cnd;
    logic [3:0] m_icode, m_dstE, m_dstM, w_icode, w_dstE, w_dstM;
    logic [2:0] m_status, w_status;

    // ctrl bits: {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc}
    wire [6:0]  c1, c0, c4;
    wire [2:0]  ps1, ps0, ps4;
    wire        h1, h0, h4;
    wire [31:0] cy1, rt1, st1, bb1, cy0, rt0, st0, bb0;
    wire [3:0]  cy4, rt4, st4, bb4;

    always #5 clk = ~clk;

    y86_pipe_ctrl #(.CNT_W(32), .FWD_EN(1'b1), .RNONE(4'hF)) u1 (
        .clk(clk), .rst(rst), .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .e_icode(e_icode), .e_dstE(e_dstE), .e_dstM(e_dstM), .e_cnd(e_cnd),
        .m_icode(m_icode), .m_dstE(m_dstE), .m_dstM(m_dstM), .m_status(m_status),
        .w_icode(w_icode), .w_dstE(w_dstE), .w_dstM(w_dstM), .w_status(w_status),
        .f_stall(c1[6]), .d_stall(c1[5]), .d_bubble(c1[4]), .e_bubble(c1[3]),
        .m_bubble(c1[2]), .w_stall(c1[1]), .set_cc(c1[0]),
        .proc_status(ps1), .halted(h1), .cnt_cycles(cy1), .cnt_retired(rt1),
        .cnt_stalls(st1), .cnt_bubbles(bb1));

    y86_pipe_ctrl #(.CNT_W(32), .FWD_EN(1'b0), .RNONE(4'hF)) u0 (
        .clk(clk), .rst(rst), .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .e_icode(e_icode), .e_dstE(e_dstE), .e_dstM(e_dstM), .e_cnd(e_cnd),
        .m_icode(m_icode), .m_dstE(m_dstE), .m_dstM(m_dstM), .m_status(m_status),
        .w_icode(w_icode), .w_dstE(w_dstE), .w_dstM(w_dstM), .w_status(w_status),
        .f_stall(c0[6]), .d_stall(c0[5]), .d_bubble(c0[4]), .e_bubble(c0[3]),
        .m_bubble(c0[2]), .w_stall(c0[1]), .set_cc(c0[0]),
        .proc_status(ps0), .halted(h0), .cnt_cycles(cy0), .cnt_retired(rt0),
        .cnt_stalls(st0), .cnt_bubbles(bb0));

    y86_pipe_ctrl #(.CNT_W(4), .FWD_EN(1'b1), .RNONE(4'hF)) u4 (
        .clk(clk), .rst(rst), .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .e_icode(e_icode), .e_dstE(e_dstE), .e_dstM(e_dstM), .e_cnd(e_cnd),
        .m_icode(m_icode), .m_dstE(m_dstE), .m_dstM(m_dstM), .m_status(m_status),
        .w_icode(w_icode), .w_dstE(w_dstE), .w_dstM(w_dstM), .w_status(w_status),
        .f_stall(c4[6]), .d_stall(c4[5]), .d_bubble(c4[4]), .e_bubble(c4[3]),
        .m_bubble(c4[2]), .w_stall(c4[1]), .set_cc(c4[0]),
        .proc_status(ps4), .halted(h4), .cnt_cycles(cy4), .cnt_retired(rt4),
        .cnt_stalls(st4), .cnt_bubbles(bb4));

    typedef struct {
        logic [3:0] d_icode, d_srcA, d_srcB, e_icode, e_dstE, e_dstM;
        logic       e_cnd;
        logic [3:0] m_icode, m_dstE, m_dstM;
        logic [2:0] m_status;
        logic [3:0] w_dstE;
        logic [6:0] exp1, exp0;
    } vec_t;

    typedef struct packed {
        logic [6:0] e1;
        logic [6:0] e0;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int m_cyc = 0, m_ret = 0, m_stl = 0, m_bub = 0;
    bit m_halt = 1'b0;
    logic [6:0] cur_exp = 7'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        d_icode = NOP; d_srcA = RN; d_srcB = RN;
        e_icode = NOP; e_dstE = RN; e_dstM = RN; e_cnd = 1'b1;
        m_icode = NOP; m_dstE = RN; m_dstM = RN; m_status = AOK;
        w_icode = NOP; w_dstE = RN; w_dstM = RN; w_status = AOK;
        cur_exp = m_halt ? 7'b0000110 : 7'b0000000;
    endtask

    task automatic push_exp(input logic [6:0] e1, input logic [6:0] e0);
        exp_t e;
        e.e1 = e1;
        e.e0 = e0;
        cur_exp = e1;
        sb.push_back(e);
    endtask

    task automatic apply(input vec_t v);
        d_icode = v.d_icode; d_srcA = v.d_srcA; d_srcB = v.d_srcB;
        e_icode = v.e_icode; e_dstE = v.e_dstE; e_dstM = v.e_dstM; e_cnd = v.e_cnd;
        m_icode = v.m_icode; m_dstE = v.m_dstE; m_dstM = v.m_dstM; m_status = v.m_status;
        w_dstE = v.w_dstE;
        push_exp(v.exp1, v.exp0);
    endtask

    task automatic check_ctrl(input string name);
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got ctrl %0h expected an entry", name, c1);
        end else begin
            e = sb.pop_front();
            chk({name, " fwd1"}, 64'(c1), 64'(e.e1));
            chk({name, " fwd0"}, 64'(c0), 64'(e.e0));
            chk({name, " cnt4"}, 64'(c4), 64'(e.e1));
        end
    endtask

    // Reference counters advance from the bench's own expected controls.
    task automatic tick();
        if (!m_halt) begin
            m_cyc++;
            if (w_status == AOK && w_icode != NOP) m_ret++;
            if (cur_exp[6]) m_stl++;
            if (cur_exp[4] || cur_exp[3]) m_bub++;
            if (w_status != AOK) m_halt = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string name);
        @(negedge clk);
        chk({name, " cycles"},  64'(cy1), 64'(m_cyc));
        chk({name, " retired"}, 64'(rt1), 64'(m_ret));
        chk({name, " stalls"},  64'(st1), 64'(m_stl));
        chk({name, " bubbles"}, 64'(bb1), 64'(m_bub));
        chk({name, " cycles4"}, 64'(cy4), 64'((m_cyc > 15) ? 15 : m_cyc));
    endtask

    // Entered just after a rising edge; reset pulses entirely between edges.
    task automatic do_reset(input string name);
        #2 rst = 1'b1;
        #1;
        chk({name, " cy1"}, 64'(cy1), 64'd0);
        chk({name, " st1"}, 64'(st1), 64'd0);
        chk({name, " bb1"}, 64'(bb1), 64'd0);
        chk({name, " rt1"}, 64'(rt1), 64'd0);
        chk({name, " cy4"}, 64'(cy4), 64'd0);
        chk({name, " ps1"}, 64'(ps1), 64'(AOK));
        chk({name, " h1"},  64'(h1),  64'd0);
        chk({name, " ctrl"}, 64'(c1), 64'd0);
        #2 rst = 1'b0;
        m_cyc = 0; m_ret = 0; m_stl = 0; m_bub = 0; m_halt = 1'b0;
        set_idle();
        tick();
    endtask

    always @(negedge clk) begin
        checks++;
        if ((c1[5] && c1[4]) || (c0[5] && c0[4]) || (c4[5] && c4[4])) begin
            errors++;
            $display("FAIL d_stall_and_d_bubble: got fwd1=%b fwd0=%b cnt4=%b expected never both", c1[5:4], c0[5:4], c4[5:4]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //            d_ic d_sA d_sB e_ic   e_dE e_dM cnd m_ic m_dE m_dM m_st w_dE exp1        exp0
        vecs[0]  = '{NOP, RN,  RN,  NOP,   RN,  RN, 1'b1, NOP, RN,  RN, AOK, RN, 7'b0000000, 7'b0000000};
        vecs[1]  = '{NOP, 4'd3,RN,  MRMOV, RN, 4'd3,1'b1, NOP, RN,  RN, AOK, RN, 7'b1101000, 7'b1101000};
        vecs[2]  = '{NOP, 4'd3,RN,  OPQ,  4'd3, RN, 1'b1, NOP, RN,  RN, AOK, RN, 7'b0000001, 7'b1101001};
        vecs[3]  = '{NOP, RN,  RN,  JXX,   RN,  RN, 1'b0, NOP, RN,  RN, AOK, RN, 7'b0011000, 7'b0011000};
        vecs[4]  = '{RET, RN,  RN,  NOP,   RN,  RN, 1'b1, NOP, RN,  RN, AOK, RN, 7'b1010000, 7'b1010000};
        vecs[5]  = '{NOP, RN, 4'd5, NOP,   RN,  RN, 1'b1, NOP,4'd5, RN, AOK, RN, 7'b0000000, 7'b1101000};
        vecs[6]  = '{NOP, RN, 4'd5, JXX,   RN,  RN, 1'b0, NOP,4'd5, RN, AOK, RN, 7'b0011000, 7'b0011000};
        vecs[7]  = '{RET, 4'd3,RN,  MRMOV, RN, 4'd3,1'b1, NOP, RN,  RN, AOK, RN, 7'b1101000, 7'b1101000};
        vecs[8]  = '{NOP, RN,  RN,  OPQ,   RN,  RN, 1'b1, NOP, RN,  RN, ADR, RN, 7'b0000100, 7'b0000100};
        vecs[9]  = '{NOP, RN, 4'd7, POP,   RN, 4'd7,1'b1, NOP, RN,  RN, AOK, RN, 7'b1101000, 7'b1101000};
        vecs[10] = '{NOP, RN,  RN,  MRMOV, RN,  RN, 1'b1, NOP, RN,  RN, AOK, RN, 7'b0000000, 7'b0000000};
        vecs[11] = '{NOP, RN,  RN,  NOP,   RN,  RN, 1'b1, RET, RN,  RN, AOK, RN, 7'b1010000, 7'b1010000};
        vecs[12] = '{NOP, 4'd2,RN,  NOP,   RN,  RN, 1'b1, NOP, RN, 4'd2,AOK, RN, 7'b0000000, 7'b1101000};
        vecs[13] = '{NOP, 4'd6,RN,  IRMOV,4'd6, RN, 1'b1, NOP, RN,  RN, AOK, RN, 7'b0000000, 7'b1101000};
        vecs[14] = '{NOP, RN, 4'd9, NOP,   RN,  RN, 1'b1, NOP, RN,  RN, AOK,4'd9,7'b0000000, 7'b1101000};
        vecs[15] = '{NOP, RN, 4'd5, RET,   RN,  RN, 1'b1, NOP,4'd5, RN, AOK, RN, 7'b1010000, 7'b1101000};

        // Hazardous inputs during reset must not leak onto the controls.
        rst = 1'b1;
        set_idle();
        e_icode = JXX; e_cnd = 1'b0; m_status = ADR; d_icode = RET;
        #12;
        chk("reset ctrl fwd1", 64'(c1), 64'd0);
        chk("reset ctrl fwd0", 64'(c0), 64'd0);
        chk("reset status", 64'(ps1), 64'(AOK));
        chk("reset halted", 64'(h1), 64'd0);
        chk("reset cycles", 64'(cy1), 64'd0);
        set_idle();
        @(posedge clk);
        #1 rst = 1'b0;

        w_icode = IRMOV;
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i]);
            check_ctrl($sformatf("vec%0d", i));
            tick();
        end
        set_idle();
        check_counters("after table");
        tick();

        // Single-cycle mispredict adds exactly one bubble cycle.
        e_icode = JXX; e_cnd = 1'b0;
        push_exp(7'b0011000, 7'b0011000);
        check_ctrl("mispredict");
        tick();
        set_idle();
        check_counters("after mispredict");
        tick();

        // RET walking D -> E -> M.
        do_reset("reset before ret");
        d_icode = RET;
        push_exp(7'b1010000, 7'b1010000);
        check_ctrl("ret in d");
        tick();
        d_icode = NOP; e_icode = RET;
        push_exp(7'b1010000, 7'b1010000);
        check_ctrl("ret in e");
        tick();
        e_icode = NOP; m_icode = RET;
        push_exp(7'b1010000, 7'b1010000);
        check_ctrl("ret in m");
        tick();
        set_idle();
        push_exp(7'b0000000, 7'b0000000);
        check_ctrl("ret gone");
        chk("ret stalls", 64'(st1), 64'd3);
        chk("ret bubbles", 64'(bb1), 64'd3);
        tick();

        // Narrow counter saturation.
        do_reset("reset before sat");
        repeat (20) tick();
        check_counters("saturation");
        chk("sat cycles4", 64'(cy4), 64'd15);
        chk("sat cycles32", 64'(cy1), 64'd21);
        tick();

        // Halt on HLT reaching W; eleventh counted cycle is the halting one.
        do_reset("reset before halt");
        w_icode = OPQ;
        repeat (9) tick();
        w_status = HLT; e_icode = OPQ;
        push_exp(7'b0000110, 7'b0000110);
        check_ctrl("exc in w");
        tick();
        w_status = AOK;
        push_exp(7'b0000110, 7'b0000110);
        check_ctrl("halted ctrl");
        chk("halt status fwd1", 64'(ps1), 64'(HLT));
        chk("halt status fwd0", 64'(ps0), 64'(HLT));
        chk("halted fwd1", 64'(h1), 64'd1);
        chk("halted cnt4", 64'(h4), 64'd1);
        repeat (5) tick();
        m_status = ADR; w_status = ADR;
        check_counters("halted counters");
        chk("halt cycles", 64'(cy1), 64'd11);
        chk("halt retired", 64'(rt1), 64'd9);
        chk("halt status frozen", 64'(ps1), 64'(HLT));
        chk("halt mbubble wstall setcc", 64'(c1[2:0]), 64'b110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
